// File: rtl/banked_mem_ctrl.sv
// banked_mem_ctrl: SFRs, banked GP RAM, banked I/O window, prioritised IRQs.
// Optional macro BANKED_MEM_IRQ_NEST_EN enables nested interrupts up to IRQ_DEPTH.
module banked_mem_ctrl #(
  parameter int NUM_BANKS = 4,
  parameter int NUM_IRQ   = 8,
  parameter int IRQ_DEPTH = 4,
  parameter int GP_DEPTH  = 240,
  localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pause,
  input  logic                zin,
  input  logic                z_write,
  input  logic                cin,
  input  logic                c_write,
  output logic                cout,
  input  logic                retint,
  input  logic [7:0]          writeaddr,
  input  logic [7:0]          writedata,
  input  logic                write_en,
  input  logic [7:0]          readaddr,
  output logic [7:0]          readdata,
  input  logic [NUM_IRQ-1:0]  io_interrupts,
  output logic [BANK_W+2:0]   io_readaddr,
  output logic [BANK_W+2:0]   io_writeaddr,
  output logic [7:0]          io_writedata,
  output logic                io_write_en,
  output logic                interrupt,
  output logic [2:0]          irq_vector,
  output logic [3:0]          irq_level,
  input  logic                accum_write,
  output logic [7:0]          accum_out
);

`ifdef BANKED_MEM_IRQ_NEST_EN
  localparam int DEPTH = IRQ_DEPTH;
`else
  localparam int DEPTH = 1;
`endif
  localparam int SP_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int GP_AW = (GP_DEPTH > 1) ? $clog2(GP_DEPTH) : 1;
  localparam logic [8:0] GP_LIM  = 9'(GP_DEPTH);
  localparam logic [3:0] LVL_MAX = 4'(DEPTH);

  logic [7:0]         status, accum;
  logic [NUM_IRQ-1:0] intcon, intstatus;
  logic [7:0]         ind [4];
  logic [3:0]         lvl;
  logic [2:0]         vec;
  logic               irq_q;

  logic [7:0]         raddr_q, waddr_q, wdata_q;
  logic               wen_q;
  logic [BANK_W-1:0]  rbank_q;

  logic [7:0] stk_st [1<<SP_W];
  logic [7:0] stk_ac [1<<SP_W];
  logic [7:0] ram [1<<BANK_W][GP_DEPTH];

  logic               st_wr, pop, entry, w_in, r_in;
  logic [BANK_W-1:0]  bank;
  logic [NUM_IRQ-1:0] pend;
  logic [7:0]         st_flags, acc_nxt, woff, roff;
  logic [2:0]         first_idx;
  logic [SP_W-1:0]    sp_push, sp_pop;

  assign st_wr   = write_en && (writeaddr == 8'h01);
  assign bank    = st_wr ? writedata[4 +: BANK_W] : status[4 +: BANK_W];
  assign pend    = intcon & io_interrupts;
  assign pop     = retint && (lvl != 4'd0);
  assign entry   = status[7] && (|pend) && (lvl < LVL_MAX)
                   && !retint && !pause;
  assign acc_nxt = accum_write ? writedata : accum;
  assign sp_push = lvl[SP_W-1:0];
  assign sp_pop  = SP_W'(lvl - 4'd1);
  assign woff    = writeaddr - 8'h10;
  assign roff    = raddr_q - 8'h10;
  assign w_in    = (writeaddr >= 8'h10) && ({1'b0, woff} < GP_LIM);
  assign r_in    = (raddr_q >= 8'h10) && ({1'b0, roff} < GP_LIM);

  assign cout         = status[1];
  assign interrupt    = irq_q;
  assign irq_vector   = vec;
  assign irq_level    = lvl;
  assign accum_out    = accum;
  assign io_readaddr  = {bank, readaddr[2:0]};
  assign io_writeaddr = {bank, writeaddr[2:0]};
  assign io_writedata = writedata;
  assign io_write_en  = !pause && write_en && (writeaddr[7:3] == 5'd1);

  // status after this cycle's write or ALU flag updates
  always_comb begin
    st_flags = status;
    if (st_wr) begin
      st_flags = writedata;
    end else begin
      if (z_write) st_flags[0] = zin;
      if (c_write) st_flags[1] = cin;
    end
  end

  // lowest pending source wins
  always_comb begin
    first_idx = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (pend[i]) first_idx = 3'(i);
  end

  // read decode from registered address, with write forwarding
  always_comb begin
    readdata = 8'h00;
    if (wen_q && (raddr_q == waddr_q)) begin
      readdata = wdata_q;
    end else begin
      unique case (1'b1)
        raddr_q == 8'h01:      readdata = status;
        raddr_q == 8'h02:      readdata = 8'(intcon);
        raddr_q == 8'h03:      readdata = 8'(intstatus);
        raddr_q[7:2] == 6'd1:  readdata = ind[raddr_q[1:0]];
        r_in:                  readdata = ram[rbank_q][roff[GP_AW-1:0]];
        default:               readdata = 8'h00;
      endcase
    end
  end

  // registers, pipeline and interrupt sequencing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status    <= '0;
      accum     <= '0;
      intcon    <= '0;
      intstatus <= '0;
      for (int i = 0; i < 4; i++) ind[i] <= '0;
      lvl       <= '0;
      vec       <= '0;
      irq_q     <= 1'b0;
      raddr_q   <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wen_q     <= 1'b0;
      rbank_q   <= '0;
    end else begin
      irq_q <= entry;
      if (!pause) begin
        raddr_q <= readaddr;
        rbank_q <= bank;
        waddr_q <= writeaddr;
        wdata_q <= writedata;
        wen_q   <= write_en;
        if (write_en && writeaddr == 8'h02)
          intcon <= writedata[NUM_IRQ-1:0];
        if (write_en && writeaddr == 8'h03)
          intstatus <= writedata[NUM_IRQ-1:0];
        if (write_en && writeaddr[7:2] == 6'd1)
          ind[writeaddr[1:0]] <= writedata;
        if (pop) begin
          status    <= stk_st[sp_pop] | 8'h80;
          accum     <= stk_ac[sp_pop];
          lvl       <= lvl - 4'd1;
          intstatus <= '0;
        end else if (entry) begin
          status    <= {1'b0, st_flags[6:0]};
          accum     <= acc_nxt;
          lvl       <= lvl + 4'd1;
          intstatus <= pend;
          vec       <= first_idx;
        end else begin
          status <= (retint && !st_wr) ? (st_flags | 8'h80) : st_flags;
          accum  <= acc_nxt;
        end
      end
    end
  end

  // context stack push and GP RAM write (contents not reset)
  always_ff @(posedge clk) begin
    if (!pause && entry) begin
      stk_st[sp_push] <= st_flags;
      stk_ac[sp_push] <= acc_nxt;
    end
    if (!pause && write_en && w_in)
      ram[bank][woff[GP_AW-1:0]] <= writedata;
  end

endmodule

// File: doc/banked_mem_ctrl.md
# banked_mem_ctrl

Parametrised data-memory controller for the 8-bit core: special-function registers, banked general-purpose RAM, a banked I/O window and a prioritised interrupt controller with a hardware context stack. It sits between the execute stage and the I/O bus. It generalises the earlier single-level controller with configurable bank count, interrupt source count and nesting depth. Interrupt entry pushes accumulator and status automatically; `retint` pops them.

## Interface
Parameters:
- `NUM_BANKS`, 4: GP/I-O banks; allowed values are 1, 2, 4, 8. `BANK_W = max(1, clog2(NUM_BANKS))`.
- `NUM_IRQ`, 8: interrupt sources, 1..8.
- `IRQ_DEPTH`, 4: context stack entries, 1..8.
- `GP_DEPTH`, 240: GP bytes per bank, at addresses 0x10..0x10+GP_DEPTH-1.

Ports:
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high.
- `pause` in 1: freezes all state updates.
- `zin`, `z_write`, `cin`, `c_write` in 1 each: flag updates from the ALU.
- `cout` out 1: `status[1]`.
- `retint` in 1: return from interrupt.
- `writeaddr` in 8, `writedata` in 8, `write_en` in 1: write port.
- `readaddr` in 8: read address.
- `readdata` out 8: read data, one cycle after `readaddr`.
- `io_interrupts` in NUM_IRQ: level-sensitive request lines.
- `io_readaddr` out BANK_W+3: `{bank, readaddr[2:0]}`.
- `io_writeaddr` out BANK_W+3: `{bank, writeaddr[2:0]}`.
- `io_writedata` out 8, `io_write_en` out 1: I/O write strobe.
- `interrupt` out 1: one-cycle entry pulse.
- `irq_vector` out 3: index of the serviced source.
- `irq_level` out 4: current stack depth.
- `accum_write` in 1: load accumulator from `writedata`.
- `accum_out` out 8: accumulator.

## Operation
Address map:
- 0x00 reads 0; writes are ignored.
- 0x01 `status`: bit0 Z, bit1 C, bits 6:4 bank (low BANK_W bits used, upper bits stored), bit7 GIE.
- 0x02 `intcon`: enable mask; low NUM_IRQ bits.
- 0x03 `intstatus`.
- 0x04–0x07: four indirect registers.
- 0x08–0x0F: I/O window; `io_write_en = write_en && writeaddr[7:3]==1`.
- 0x10 upward: GP RAM, indexed by bank. Reads beyond GP_DEPTH return 0; writes beyond GP_DEPTH are dropped.

Bank selection:
- A same-cycle write to `status` forwards `writedata[6:4]` as the bank for that cycle's read and write addressing.

Reads:
- Address and bank are registered; `readdata` is then decoded combinationally.
- If the registered read address equals the registered write address and the registered `write_en` was set, the registered `writedata` is returned. This holds for every region, including RAM.

Flags:
- Writing `status` suppresses `z_write`, `c_write` and the GIE effect of `retint` in that cycle.

Interrupt entry condition:
- `pend = intcon & io_interrupts`.
- Entry occurs when all of these hold: GIE=1, `pend`≠0, `irq_level`<IRQ_DEPTH, `retint`=0 and `pause`=0.

Interrupt entry actions, in the same edge:
- Push {`status` after this cycle's flag updates, `accum`}.
- `irq_level`+1.
- GIE←0.
- `intstatus`←`pend`.
- `irq_vector`←index of the lowest set bit of `pend`.
- `interrupt`=1 for that one cycle.
- Entry overrides any write to GIE in the same cycle; other status bits follow the write.

`retint` when `irq_level`>0:
- Pop and restore `status` and `accum`.
- Force GIE←1.
- `irq_level`−1.
- `intstatus`←0.
- `retint` overrides `accum_write` in the same cycle.

`retint` when `irq_level`=0:
- GIE←1 only.

Pause:
- `pause`=1 blocks every register, RAM, stack and pipeline update.
- Outputs hold their values; `interrupt` is 0.

## Timing
- Read latency is one cycle.
- Writes take effect at the edge.
- Interrupt entry is taken at the first edge where the condition holds. The ISR sees the saved context at that edge.
- `retint` followed by an eligible pending request: entry is taken no earlier than the next edge.
- Reset values (asynchronous): `status`, `intcon`, `intstatus`, `accum` and indirect registers = 0. `irq_level` = 0, `irq_vector` = 0, `interrupt` = 0. Pipeline registers = 0, so `readdata` = 0. RAM contents are not reset.
- Reset during an ISR discards the stack.

## Configuration
- `BANKED_MEM_IRQ_NEST_EN` defined:
  - Nesting up to IRQ_DEPTH is allowed; software re-enables GIE inside an ISR.
  - When the stack is full, the request is held pending and not dropped.
- `BANKED_MEM_IRQ_NEST_EN` undefined:
  - The effective depth is 1; no entry occurs while `irq_level`=1, even if GIE=1.
  - The stack reduces to one register; `irq_level` is 0 or 1.

## Test plan
- Reset: assert `reset` mid-cycle → all outputs 0 immediately; `irq_level`=0.
- Bank switch: write `status`=0x20 and in the same cycle write 0x10←0xAA; then select bank 0 and write 0x10←0x55. Read 0x10 with bank 2 → 0xAA; with bank 0 → 0x55.
- Forwarding: write 0x05←0x3C and read 0x05 in the same cycle → `readdata`=0x3C next cycle.
- Priority: `intcon`=0xFF, GIE=1, `io_interrupts`=0x28 → `interrupt` pulse, `irq_vector`=3, `intstatus`=0x28, GIE=0, `irq_level`=1.
- Nesting (macro defined, IRQ_DEPTH=2):
  - Set GIE in the ISR and raise a second request → `irq_level`=2.
  - With GIE set again, a third request is held.
  - Two `retint`s restore the original accum and status; GIE=1, `irq_level`=0.
- Pause: `pause`=1 with an eligible request and `write_en` → no state changes. Entry occurs on the first unpaused edge.
